// File: rtl/hazard_stall_unit.sv
// Decode-stage hazard detector: per-register pending scoreboard, multiplier
// busy tracking, stall/bubble/flush generation and a saturating stall counter.
module hazard_stall_unit #(
   parameter int LOAD_LAT = 1,
   parameter int MUL_LAT  = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        D_valid,
   input  logic [4:0]  D_rs,
   input  logic [4:0]  D_rt,
   input  logic        D_usesRs,
   input  logic        D_usesRt,
   input  logic [4:0]  D_rd,
   input  logic        D_regWrite,
   input  logic        D_memRead,
   input  logic        D_mul,
   input  logic        X_branchTaken,
   output logic        stall,
   output logic        bubble,
   output logic        flush,
   output logic [15:0] stallCount
);

   localparam logic [1:0] LOAD_V = 2'(LOAD_LAT);
   localparam logic [1:0] MUL_V  = 2'(MUL_LAT);

   logic [1:0]  pend_q [32];
   logic [1:0]  pend_d [32];
   logic [1:0]  mul_busy_q, mul_busy_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic        raw, waw, strc, issue;

   always_comb begin
      raw = D_valid &&
            ((D_usesRs && (pend_q[D_rs] != 2'd0)) ||
             (D_usesRt && (pend_q[D_rt] != 2'd0)));
      waw = D_valid && D_regWrite && (D_rd != 5'd0) &&
            (pend_q[D_rd] != 2'd0);
      strc = D_valid && D_mul && (mul_busy_q != 2'd0);
      stall = (raw || waw || strc) && !X_branchTaken;
      bubble = stall || X_branchTaken;
      flush = X_branchTaken;
      issue = D_valid && !stall && !X_branchTaken;
   end

   always_comb begin
      for (int i = 0; i < 32; i++) begin
         pend_d[i] = (pend_q[i] != 2'd0) ? pend_q[i] - 2'd1 : 2'd0;
      end
      // Issue overrides the decrement of the destination entry
      if (issue && D_regWrite && (D_rd != 5'd0)) begin
         if (D_mul) pend_d[D_rd] = MUL_V;
         else if (D_memRead) pend_d[D_rd] = LOAD_V;
         else pend_d[D_rd] = 2'd0;
      end
      pend_d[0] = 2'd0;
      mul_busy_d = (mul_busy_q != 2'd0) ? mul_busy_q - 2'd1 : 2'd0;
      if (issue && D_mul) mul_busy_d = MUL_V;
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) pend_q[i] <= 2'd0;
         mul_busy_q  <= 2'd0;
         stall_cnt_q <= 16'd0;
      end else begin
         for (int i = 0; i < 32; i++) pend_q[i] <= pend_d[i];
         mul_busy_q  <= mul_busy_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: a reference model predicts
// stall/bubble/flush/stallCount per cycle, queued and compared at negedge.
module tb_hazard_stall_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        D_valid;
   logic [4:0]  D_rs, D_rt, D_rd;
   logic        D_usesRs, D_usesRt;
   logic        D_regWrite, D_memRead, D_mul;
   logic        X_branchTaken;
   logic        stall, bubble, flush;
   logic [15:0] stallCount;

   int n_cmp = 0;
   int n_bad = 0;

   int m_pend [32];
   int m_mb;
   int m_cnt;
   logic [18:0] exp_q [$];

   hazard_stall_unit #(.LOAD_LAT(1), .MUL_LAT(3)) dut (
      .clk(clk), .rst(rst), .D_valid(D_valid),
      .D_rs(D_rs), .D_rt(D_rt),
      .D_usesRs(D_usesRs), .D_usesRt(D_usesRt),
      .D_rd(D_rd), .D_regWrite(D_regWrite),
      .D_memRead(D_memRead), .D_mul(D_mul),
      .X_branchTaken(X_branchTaken),
      .stall(stall), .bubble(bubble), .flush(flush),
      .stallCount(stallCount)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                  $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_pend[i] = 0;
      m_mb = 0;
      m_cnt = 0;
   endtask

   // One decode cycle: drive, predict, compare at negedge, advance model
   task automatic step(input logic v, input int rs, input int rt,
                       input logic urs, input logic urt, input int rd,
                       input logic rw, input logic mr, input logic mu,
                       input logic br);
      logic hz, es, ei;
      logic [18:0] e, g;
      D_valid = v; D_rs = 5'(rs); D_rt = 5'(rt);
      D_usesRs = urs; D_usesRt = urt; D_rd = 5'(rd);
      D_regWrite = rw; D_memRead = mr; D_mul = mu;
      X_branchTaken = br;
      hz = v && ((urs && m_pend[rs] != 0 && rs != 0) ||
                 (urt && m_pend[rt] != 0 && rt != 0) ||
                 (rw && rd != 0 && m_pend[rd] != 0) ||
                 (mu && m_mb != 0));
      es = hz && !br;
      ei = v && !es && !br;
      exp_q.push_back({es, es || br, br, 16'(m_cnt)});
      @(negedge clk);
      e = exp_q.pop_front();
      g = {stall, bubble, flush, stallCount};
      check("stall", 32'(g[18]), 32'(e[18]));
      check("bubble", 32'(g[17]), 32'(e[17]));
      check("flush", 32'(g[16]), 32'(e[16]));
      check("stallCount", 32'(g[15:0]), 32'(e[15:0]));
      @(posedge clk);
      for (int i = 0; i < 32; i++) if (m_pend[i] > 0) m_pend[i]--;
      if (m_mb > 0) m_mb--;
      if (ei && rw && rd != 0) m_pend[rd] = mu ? 3 : (mr ? 1 : 0);
      if (ei && mu) m_mb = 3;
      if (es && m_cnt < 65535) m_cnt++;
      #1;
   endtask

   task automatic idle();
      step(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      model_reset();
      rst = 1'b1;
      D_valid = 1'b1; D_rs = 5'd1; D_rt = 5'd2;
      D_usesRs = 1'b1; D_usesRt = 1'b1; D_rd = 5'd3;
      D_regWrite = 1'b1; D_memRead = 1'b1; D_mul = 1'b1;
      X_branchTaken = 1'b0;
      #12;
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_bubble", 32'(bubble), 32'd0);
      check("rst_cnt", 32'(stallCount), 32'd0);
      X_branchTaken = 1'b1;
      #1;
      check("rst_flush_br", 32'(flush), 32'd1);
      check("rst_bubble_br", 32'(bubble), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      idle();

      // Load-use: exactly one stall
      step(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
      step(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
      step(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
      check("load_use_cnt", 32'(stallCount), 32'd1);

      // Mul-use on rt: three stalls
      step(1, 0, 0, 0, 0, 7, 1, 0, 1, 0);
      for (int i = 0; i < 4; i++) step(1, 0, 7, 0, 1, 0, 0, 0, 0, 0);
      // Back-to-back muls: structural stall
      idle(); idle(); idle();
      step(1, 0, 0, 0, 0, 8, 1, 0, 1, 0);
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 9, 1, 0, 1, 0);
      idle(); idle(); idle();

      // ALU forwarding, r0 writes/reads, ignored source fields, WAW
      step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
      step(1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      step(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
      step(1, 5, 5, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 10, 1, 1, 0, 0);
      step(1, 0, 0, 0, 0, 10, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 10, 1, 0, 0, 0);

      // Branch beats a load-use hazard; squashed load is not recorded
      step(1, 0, 0, 0, 0, 11, 1, 1, 0, 0);
      step(1, 11, 0, 1, 0, 12, 1, 1, 0, 1);
      step(1, 12, 0, 1, 0, 0, 0, 0, 0, 0);

      // Async reset in the middle of a mul stall
      step(1, 0, 0, 0, 0, 13, 1, 0, 1, 0);
      step(1, 13, 0, 1, 0, 0, 0, 0, 0, 0);
      D_valid = 1'b1; D_rs = 5'd13; D_usesRs = 1'b1;
      D_regWrite = 1'b0; D_mul = 1'b0; X_branchTaken = 1'b0;
      #1;
      check("pre_rst_stall", 32'(stall), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      check("mid_rst_stall", 32'(stall), 32'd0);
      check("mid_rst_cnt", 32'(stallCount), 32'd0);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      step(1, 13, 0, 1, 0, 0, 0, 0, 0, 0);

      // Random traffic over a few registers
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), $urandom_range(0, 3),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 9) == 0));
      end

      // Self-dependent mul chain to saturate the stall counter
      for (int i = 0; i < 88000; i++) begin
         step(1, 20, 0, 1, 0, 20, 1, 0, 1, 0);
      end
      check("sat_cnt", 32'(stallCount), 32'h0000FFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
